// File: rtl/register_file.sv
// MIPS-style architectural register file: two combinational read ports, one write port.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read buses.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       instruction,
    input  logic              reg_dst,
    input  logic              reg_write,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] busA,
    output logic [DATA_W-1:0] busB,
    output logic [ADDR_W-1:0] rw
);
    localparam int NREG = 2 ** ADDR_W;

    logic [ADDR_W-1:0] rs, rt, rd;
    logic [DATA_W-1:0] regs [1:NREG-1];
    logic [DATA_W-1:0] rd_a, rd_b;
    logic              unused_insn;

    assign rs = instruction[25:21];
    assign rt = instruction[20:16];
    assign rd = instruction[15:11];
    assign rw = reg_dst ? rd : rt;
    assign unused_insn = ^{instruction[31:26], instruction[10:0]};

    // Entry 0 has no flop; writes addressed to it match no entry and vanish.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < NREG; i++) regs[i] <= '0;
        end else if (reg_write) begin
            for (int i = 1; i < NREG; i++)
                if (rw == ADDR_W'(i)) regs[i] <= wr_data;
        end
    end

    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs == ADDR_W'(i)) rd_a = regs[i];
            if (rt == ADDR_W'(i)) rd_b = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic fwd_a, fwd_b;
    assign fwd_a = reg_write && (rw == rs) && (rs != '0);
    assign fwd_b = reg_write && (rw == rt) && (rt != '0);
    assign busA  = rst ? '0 : (fwd_a ? wr_data : rd_a);
    assign busB  = rst ? '0 : (fwd_b ? wr_data : rd_b);
`else
    assign busA = rst ? '0 : rd_a;
    assign busB = rst ? '0 : rd_b;
`endif
endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
module tb_register_file;
    logic        clk;
    logic        rst;
    logic [31:0] instruction;
    logic        reg_dst;
    logic        reg_write;
    logic [31:0] wr_data;
    logic [31:0] busA, busB;
    logic [4:0]  rw;

    int errors = 0;
    int checks = 0;

    register_file #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .instruction(instruction), .reg_dst(reg_dst),
        .reg_write(reg_write), .wr_data(wr_data), .busA(busA), .busB(busB), .rw(rw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 11'h000};
    endfunction

    // write val into register idx via the rd field, then leave write disabled
    task automatic wr_reg(input logic [4:0] idx, input logic [31:0] val);
        @(negedge clk);
        instruction = mk(5'd0, 5'd0, idx);
        reg_dst = 1'b1; reg_write = 1'b1; wr_data = val;
        @(posedge clk); #1;
        reg_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; reg_write = 1'b0; reg_dst = 1'b1; wr_data = '0;
        instruction = mk(5'd5, 5'd6, 5'd13);
        #2;
        checks++; if (busA !== 32'h0 || busB !== 32'h0) begin errors++;
            $display("FAIL reset_bus: busA=%h busB=%h want 0", busA, busB); end
        checks++; if (rw !== 5'd13) begin errors++;
            $display("FAIL reset_rw: rw=%0d want 13", rw); end
        @(negedge clk); rst = 1'b0;
        wr_reg(5'd5, 32'hDEADBEEF);
        instruction = mk(5'd5, 5'd0, 5'd0); #1;
        checks++; if (busA !== 32'hDEADBEEF) begin errors++;
            $display("FAIL reset_prewrite: busA=%h want deadbeef", busA); end
        #1 rst = 1'b1; #1;
        checks++; if (busA !== 32'h0) begin errors++;
            $display("FAIL reset_async_clear: busA=%h want 0", busA); end
        #1 rst = 1'b0; #1;
        checks++; if (busA !== 32'h0) begin errors++;
            $display("FAIL reset_after_fall: busA=%h want 0", busA); end
        // write whose edge coincides with rst=1 must be lost
        @(negedge clk);
        instruction = mk(5'd5, 5'd0, 5'd5); reg_write = 1'b1; wr_data = 32'h11112222;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); rst = 1'b0; reg_write = 1'b0; #1;
        checks++; if (busA !== 32'h0) begin errors++;
            $display("FAIL reset_write_lost: busA=%h want 0", busA); end
        wr_reg(5'd5, 32'h33334444);
        instruction = mk(5'd5, 5'd0, 5'd0); #1;
        checks++; if (busA !== 32'h33334444) begin errors++;
            $display("FAIL reset_first_write: busA=%h want 33334444", busA); end
    endtask

    task automatic test_rtype();
        wr_reg(5'd9, 32'h12345678);
        instruction = mk(5'd9, 5'd9, 5'd0); #1;
        checks++; if (busA !== 32'h12345678 || busB !== 32'h12345678) begin errors++;
            $display("FAIL rtype: busA=%h busB=%h want 12345678", busA, busB); end
    endtask

    task automatic test_itype();
        wr_reg(5'd20, 32'h00002020);
        @(negedge clk);
        instruction = mk(5'd0, 5'd3, 5'd20);
        reg_dst = 1'b0; reg_write = 1'b1; wr_data = 32'h000000FF; #1;
        checks++; if (rw !== 5'd3) begin errors++;
            $display("FAIL itype_rw: rw=%0d want 3", rw); end
        @(posedge clk); #1; reg_write = 1'b0;
        instruction = mk(5'd3, 5'd20, 5'd0); #1;
        checks++; if (busA !== 32'h000000FF || busB !== 32'h00002020) begin errors++;
            $display("FAIL itype: busA=%h want ff busB=%h want 00002020", busA, busB); end
    endtask

    task automatic test_zero();
        wr_reg(5'd0, 32'hFFFFFFFF);
        instruction = mk(5'd0, 5'd0, 5'd0); #1;
        checks++; if (busA !== 32'h0 || busB !== 32'h0) begin errors++;
            $display("FAIL zero_reg: busA=%h busB=%h want 0", busA, busB); end
        instruction = mk(5'd9, 5'd3, 5'd0); #1;
        checks++; if (busA !== 32'h12345678 || busB !== 32'h000000FF) begin errors++;
            $display("FAIL zero_others: busA=%h want 12345678 busB=%h want ff", busA, busB); end
        instruction = mk(5'd5, 5'd20, 5'd0); #1;
        checks++; if (busA !== 32'h33334444 || busB !== 32'h00002020) begin errors++;
            $display("FAIL zero_others2: busA=%h busB=%h", busA, busB); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'd2;
`else
        exp_pre = 32'd1;
`endif
        wr_reg(5'd7, 32'd1);
        @(negedge clk);
        instruction = mk(5'd7, 5'd7, 5'd7);
        reg_dst = 1'b1; reg_write = 1'b1; wr_data = 32'd2; #1;
        checks++; if (busA !== exp_pre || busB !== exp_pre) begin errors++;
            $display("FAIL same_cycle_pre: busA=%h busB=%h want %h", busA, busB, exp_pre); end
        @(posedge clk); #1; reg_write = 1'b0; #1;
        checks++; if (busA !== 32'd2) begin errors++;
            $display("FAIL same_cycle_post: busA=%h want 2", busA); end
    endtask

    task automatic test_gating();
        wr_reg(5'd4, 32'h00000044);
        @(negedge clk);
        instruction = mk(5'd4, 5'd0, 5'd4);
        reg_dst = 1'b1; reg_write = 1'b0; wr_data = 32'hA5A5A5A5;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (busA !== 32'h00000044) begin errors++;
            $display("FAIL write_gating: busA=%h want 44", busA); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instruction = mk(5'd0, 5'd0, 5'(10 + i));
            reg_dst = 1'b1; reg_write = 1'b1; wr_data = 32'hC0DE0000 + i;
        end
        @(posedge clk); #1; reg_write = 1'b0;
        instruction = mk(5'd10, 5'd12, 5'd0); #1;
        checks++; if (busA !== 32'hC0DE0000 || busB !== 32'hC0DE0002) begin errors++;
            $display("FAIL b2b_a: busA=%h want c0de0000 busB=%h want c0de0002", busA, busB); end
        instruction = mk(5'd11, 5'd31, 5'd0); #1;
        checks++; if (busA !== 32'hC0DE0001 || busB !== 32'h0) begin errors++;
            $display("FAIL b2b_b: busA=%h want c0de0001 busB=%h want 0", busA, busB); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_zero();
        test_same_cycle();
        test_gating();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
